// File: rtl/beta_mem_arbiter.sv
// Arbitrates one memory port between Beta_core fetch and data ports, with access timeout.
// Define BETA_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module beta_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  output logic              i_fault,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_fault,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  output logic              m_re,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_fault
);

  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_dreq;
  logic              w_any;
  logic              w_grant_d;
  logic              w_busy;
  logic              w_timeout;
  logic              w_done;

  logic              r_m_valid, w_m_valid;
  logic              r_m_we, w_m_we;
  logic              r_m_re, w_m_re;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr;
  logic [DATA_W-1:0] r_m_wdata, w_m_wdata;
  logic              r_i_ready, w_i_ready;
  logic              r_i_fault, w_i_fault;
  logic [DATA_W-1:0] r_i_data, w_i_data;
  logic              r_d_ready, w_d_ready;
  logic              r_d_fault, w_d_fault;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
  logic              w_fault_val;
  logic [DATA_W-1:0] w_data_val;

  assign w_dreq    = d_re | d_we;
  assign w_any     = w_dreq | i_req;
  assign w_busy    = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_timeout = (TIMEOUT != 0) && !m_ack && (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_done    = w_busy && (m_ack || w_timeout);
  // An aborted access reports a fault with zero data; writes never return data.
  assign w_fault_val = m_ack ? m_fault : 1'b1;
  assign w_data_val  = (m_ack && !r_m_we) ? m_rdata : {DATA_W{1'b0}};

`ifdef BETA_ARB_RR_EN
  logic r_last_d;
  // On a tie the port that did not win last time is granted.
  assign w_grant_d = (w_dreq && i_req) ? ~r_last_d : w_dreq;

  // Last-grant pointer; starts at data so the first tie goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b1;
    end else if ((r_state == S_IDLE) && w_any) begin
      r_last_d <= w_grant_d;
    end else begin
      r_last_d <= r_last_d;
    end
  end
`else
  assign w_grant_d = w_dreq;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Wait counter: cleared while idle, advances on each unacknowledged busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == S_IDLE) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_busy && !m_ack) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next = w_grant_d ? S_BUSY_D : S_BUSY_I;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (w_done) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = r_state;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_m_valid = r_m_valid;
    w_m_we    = r_m_we;
    w_m_re    = r_m_re;
    w_m_addr  = r_m_addr;
    w_m_wdata = r_m_wdata;
    w_i_ready = r_i_ready;
    w_i_fault = r_i_fault;
    w_i_data  = r_i_data;
    w_d_ready = r_d_ready;
    w_d_fault = r_d_fault;
    w_d_rdata = r_d_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_m_valid = 1'b1;
          w_m_addr  = w_grant_d ? d_addr : i_addr;
          w_m_wdata = w_grant_d ? d_wdata : {DATA_W{1'b0}};
          w_m_we    = w_grant_d & d_we;
          w_m_re    = ~(w_grant_d & d_we);
        end else begin
          w_m_valid = 1'b0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (w_done) begin
          w_m_valid = 1'b0;
          w_m_we    = 1'b0;
          w_m_re    = 1'b0;
          if (r_state == S_BUSY_D) begin
            w_d_ready = 1'b1;
            w_d_fault = w_fault_val;
            w_d_rdata = w_data_val;
          end else begin
            w_i_ready = 1'b1;
            w_i_fault = w_fault_val;
            w_i_data  = w_data_val;
          end
        end else begin
          w_m_valid = 1'b1;
        end
      end
      S_RESP: begin
        w_i_ready = 1'b0;
        w_i_fault = 1'b0;
        w_i_data  = {DATA_W{1'b0}};
        w_d_ready = 1'b0;
        w_d_fault = 1'b0;
        w_d_rdata = {DATA_W{1'b0}};
      end
      default: begin
        w_m_valid = 1'b0;
        w_m_we    = 1'b0;
        w_m_re    = 1'b0;
        w_i_ready = 1'b0;
        w_d_ready = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears the memory command immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_re    <= 1'b0;
      r_m_addr  <= {ADDR_W{1'b0}};
      r_m_wdata <= {DATA_W{1'b0}};
      r_i_ready <= 1'b0;
      r_i_fault <= 1'b0;
      r_i_data  <= {DATA_W{1'b0}};
      r_d_ready <= 1'b0;
      r_d_fault <= 1'b0;
      r_d_rdata <= {DATA_W{1'b0}};
    end else begin
      r_m_valid <= w_m_valid;
      r_m_we    <= w_m_we;
      r_m_re    <= w_m_re;
      r_m_addr  <= w_m_addr;
      r_m_wdata <= w_m_wdata;
      r_i_ready <= w_i_ready;
      r_i_fault <= w_i_fault;
      r_i_data  <= w_i_data;
      r_d_ready <= w_d_ready;
      r_d_fault <= w_d_fault;
      r_d_rdata <= w_d_rdata;
    end
  end

  assign m_valid = r_m_valid;
  assign m_we    = r_m_we;
  assign m_re    = r_m_re;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_ready = r_i_ready;
  assign i_fault = r_i_fault;
  assign i_data  = r_i_data;
  assign d_ready = r_d_ready;
  assign d_fault = r_d_fault;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Directed bench for beta_mem_arbiter (TIMEOUT=4): vector table plus arbitration, timeout and reset sequences.
module tb_beta_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ready;
  logic        i_fault;
  logic        d_re;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_fault;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic        m_re;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_fault;

  int n_chk = 0;
  int n_err = 0;

  beta_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready), .i_fault(i_fault),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_fault(d_fault),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_fault(m_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_d;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    logic        mf;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle the request is driven; returns in the ready cycle with the request dropped.
  task automatic serve(input logic exp_d, input logic [31:0] exp_addr, input logic exp_we,
                       input logic [31:0] exp_wdata, input int exp_lat, input int ack_dly,
                       input logic [31:0] rdata, input logic mf,
                       input logic [31:0] exp_data, input logic exp_fault);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!m_valid && lat < 10);
    chk("grant_latency", lat, exp_lat);
    chk("m_addr", m_addr, exp_addr);
    chk("m_we", {31'd0, m_we}, {31'd0, exp_we});
    chk("m_re", {31'd0, m_re}, {31'd0, ~exp_we});
    if (exp_we) chk("m_wdata", m_wdata, exp_wdata);
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      chk("m_valid_hold", {31'd0, m_valid}, 32'd1);
      chk("m_addr_hold", m_addr, exp_addr);
    end
    m_ack   = 1'b1;
    m_rdata = rdata;
    m_fault = mf;
    tick();
    m_ack   = 1'b0;
    m_rdata = 32'h0;
    m_fault = 1'b0;
    chk("m_valid_drop", {31'd0, m_valid}, 32'd0);
    if (exp_d) begin
      chk("d_ready", {31'd0, d_ready}, 32'd1);
      chk("d_fault", {31'd0, d_fault}, {31'd0, exp_fault});
      chk("d_rdata", d_rdata, exp_data);
      chk("i_ready_other", {31'd0, i_ready}, 32'd0);
      d_re = 1'b0;
      d_we = 1'b0;
    end else begin
      chk("i_ready", {31'd0, i_ready}, 32'd1);
      chk("i_fault", {31'd0, i_fault}, {31'd0, exp_fault});
      chk("i_data", i_data, exp_data);
      chk("d_ready_other", {31'd0, d_ready}, 32'd0);
      i_req = 1'b0;
    end
  endtask

  vec_t vecs[5];
  logic first_d;
  logic [31:0] rd;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h104, 32'h0,        0, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'h0,        1, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h304, 32'hCAFEBABE, 3, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h308, 32'h11223344, 0, 32'h89ABCDEF, 1'b1, 32'h0,        1'b1};

    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_re = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; m_ack = 1'b0; m_rdata = 32'h0; m_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_re", {31'd0, m_re}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_i_fault", {31'd0, i_fault}, 32'd0);
    chk("rst_d_fault", {31'd0, d_fault}, 32'd0);
    chk("rst_i_data", i_data, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_d) begin
        d_re = vecs[v].re; d_we = vecs[v].we; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr;
      end
      serve(vecs[v].is_d, vecs[v].addr, vecs[v].we, vecs[v].wdata, 1, vecs[v].ack_dly,
            vecs[v].rdata, vecs[v].mf, vecs[v].exp_data, vecs[v].exp_fault);
      tick();
      chk("idle_i_ready", {31'd0, i_ready}, 32'd0);
      chk("idle_d_ready", {31'd0, d_ready}, 32'd0);
    end

    // Simultaneous fetch and store, four rounds.
`ifdef BETA_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    for (int r = 0; r < 4; r++) begin
      rd = 32'h55AA0000 + 32'(r);
      i_req = 1'b1; i_addr = 32'h400;
      d_we = 1'b1; d_re = 1'b0; d_addr = 32'h200; d_wdata = 32'h12345678;
      if (first_d) begin
        serve(1'b1, 32'h200, 1'b1, 32'h12345678, 1, 0, rd, 1'b0, 32'h0, 1'b0);
        serve(1'b0, 32'h400, 1'b0, 32'h0, 2, 1, rd, 1'b0, rd, 1'b0);
      end else begin
        serve(1'b0, 32'h400, 1'b0, 32'h0, 1, 0, rd, 1'b0, rd, 1'b0);
        serve(1'b1, 32'h200, 1'b1, 32'h12345678, 2, 1, rd, 1'b0, 32'h0, 1'b0);
      end
      tick();
    end

    // Timeout: memory never acks a read.
    d_re = 1'b1; d_addr = 32'h500;
    tick();
    chk("to_m_valid_1", {31'd0, m_valid}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("to_m_valid_hold", {31'd0, m_valid}, 32'd1);
    end
    tick();
    chk("to_m_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("to_d_ready", {31'd0, d_ready}, 32'd1);
    chk("to_d_fault", {31'd0, d_fault}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    chk("to_i_ready", {31'd0, i_ready}, 32'd0);
    d_re = 1'b0;
    m_ack = 1'b1; m_rdata = 32'hFEEDFACE; m_fault = 1'b1;
    tick();
    tick();
    m_ack = 1'b0; m_rdata = 32'h0; m_fault = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_ack_d_ready", {31'd0, d_ready}, 32'd0);
      chk("late_ack_i_ready", {31'd0, i_ready}, 32'd0);
      chk("late_ack_m_valid", {31'd0, m_valid}, 32'd0);
      tick();
    end

    // Asynchronous reset in the middle of a data write.
    d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h00000077;
    tick();
    chk("mid_m_valid", {31'd0, m_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_m_we", {31'd0, m_we}, 32'd0);
    chk("arst_m_addr", m_addr, 32'd0);
    chk("arst_m_wdata", m_wdata, 32'd0);
    chk("arst_d_ready", {31'd0, d_ready}, 32'd0);
    d_we = 1'b0;
    tick();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h700;
    serve(1'b0, 32'h700, 1'b0, 32'h0, 1, 1, 32'h13579BDF, 1'b0, 32'h13579BDF, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
